mem_port_arbiter: RTL

Shares the byte-lane data memory (four rotating 8-byte BRAM banks, 32 bytes total) between the CPU memory stage and an auxiliary requester such as the program loader or debug port. It issues at most one access per cycle and drives the memory's `{store, byte_enable}` access code, address and store data. It registers the grant and address remainder so the rotated read data is steered back to the owning requester one cycle later. The CPU has priority, and a bounded-wait counter guarantees the auxiliary port progress.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port arbiter: window size, access-code
// field layout and requester encoding.
package mem_pkg;

    localparam int unsigned MEM_BYTES  = 32;
    localparam int unsigned ACC_STORE  = 4;
    localparam int unsigned ACC_BE_MSB = 3;
    localparam int unsigned ACC_BE_LSB = 0;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_AUX = 1'b1
    } owner_e;

    typedef enum logic {
        ARB_NORMAL    = 1'b0,
        ARB_FORCE_AUX = 1'b1
    } arb_state_e;

    function automatic logic [4:0] acc_code(input logic we, input logic [3:0] be);
        logic [4:0] code;
        code                        = '0;
        code[ACC_STORE]             = we;
        code[ACC_BE_MSB:ACC_BE_LSB] = be;
        return code;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the rotating byte-lane data memory. The CPU has
// priority; a bounded-wait counter forces the aux port through after MAX_WAIT refusals.
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned MEM_BYTES = mem_pkg::MEM_BYTES
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_byte_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [3:0]  aux_byte_en,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    output logic        aux_gnt,
    output logic        aux_rvalid,
    output logic [31:0] aux_rdata,
    output logic        aux_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_to_store,
    output logic [4:0]  mem_access_code,
    output logic [1:0]  mem_prev_r,
    input  logic [1:0]  mem_r,
    input  logic [31:0] mem_rdata
);
    import mem_pkg::*;

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       resp_valid_q, resp_valid_d;
    logic       resp_err_q, resp_err_d;
    owner_e     resp_owner_q, resp_owner_d;
    logic [1:0] mem_prev_r_q, mem_prev_r_d;

    arb_state_e  arb_state;
    logic        cpu_oor, aux_oor, sel_err, any_gnt, resp_live;
    owner_e      sel_owner;
    logic [31:0] rd_steer;

    // Widened to 33 bits so addresses near 2^32 cannot wrap back into the window.
    function automatic logic out_of_range(input logic [31:0] addr);
        return ({1'b0, addr} + 33'd3) >= 33'(MEM_BYTES);
    endfunction

    always_comb begin
        arb_state = (wait_cnt_q == 4'(MAX_WAIT)) ? ARB_FORCE_AUX : ARB_NORMAL;
        aux_gnt   = ~reset & aux_req & (~cpu_req | (arb_state == ARB_FORCE_AUX));
        cpu_gnt   = ~reset & cpu_req & ~aux_gnt;
        any_gnt   = cpu_gnt | aux_gnt;
        cpu_oor   = out_of_range(cpu_addr);
        aux_oor   = out_of_range(aux_addr);

        mem_access_code   = '0;
        mem_address       = '0;
        mem_data_to_store = '0;
        sel_err           = 1'b0;
        sel_owner         = OWN_CPU;
        if (aux_gnt) begin
            sel_owner         = OWN_AUX;
            sel_err           = aux_oor;
            mem_address       = aux_addr;
            mem_data_to_store = aux_wdata;
            if (!aux_oor) mem_access_code = acc_code(aux_we, aux_byte_en);
        end else if (cpu_gnt) begin
            sel_owner         = OWN_CPU;
            sel_err           = cpu_oor;
            mem_address       = cpu_addr;
            mem_data_to_store = cpu_wdata;
            if (!cpu_oor) mem_access_code = acc_code(cpu_we, cpu_byte_en);
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (aux_gnt) begin
            wait_cnt_d = '0;
        end else if (aux_req && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
        resp_valid_d = any_gnt;
        resp_err_d   = any_gnt & sel_err;
        resp_owner_d = any_gnt ? sel_owner : resp_owner_q;
        mem_prev_r_d = any_gnt ? mem_r : mem_prev_r_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wait_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_owner_q <= OWN_CPU;
            mem_prev_r_q <= '0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_owner_q <= resp_owner_d;
            mem_prev_r_q <= mem_prev_r_d;
        end
    end

    // Memory lane b holds byte (addr + b - r) mod 4; rotate right by r bytes to realign.
    always_comb begin
        rd_steer   = 32'({mem_rdata, mem_rdata} >> {mem_prev_r_q, 3'b000});
        resp_live  = resp_valid_q & ~reset;
        cpu_rvalid = resp_live & (resp_owner_q == OWN_CPU);
        aux_rvalid = resp_live & (resp_owner_q == OWN_AUX);
        cpu_err    = cpu_rvalid & resp_err_q;
        aux_err    = aux_rvalid & resp_err_q;
        cpu_rdata  = (cpu_rvalid & ~resp_err_q) ? rd_steer : '0;
        aux_rdata  = (aux_rvalid & ~resp_err_q) ? rd_steer : '0;
    end

    assign mem_prev_r = mem_prev_r_q;

endmodule
